// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//
// Recovers framed words from a single-bit serial line that is sampled once per
// clk cycle. A frame is one start bit (0), DATA_WIDTH data bits sent LSB first,
// and one stop bit (1). Each good frame updates data_out and raises a one-cycle
// output_ready strobe. A frame whose stop bit is 0 raises a one-cycle
// frame_error strobe instead. The receiver then waits for the line to return
// high before it accepts another start bit.
//
// The line comes from a transmitter on the same clock, so rx is used directly
// with no synchronizer and no glitch filtering.
//
// Ports
//   clk           in   1           rising-edge clock
//   arst          in   1           asynchronous reset, active low
//   rx            in   1           serial line, idle high
//   data_out      out  DATA_WIDTH  last correctly received word (held)
//   output_ready  out  1           one-cycle pulse when data_out updates
//   frame_error   out  1           one-cycle pulse on a stop bit sampled low
//   busy          out  1           high in any state other than IDLE
// -----------------------------------------------------------------------------
module serial_receiver #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  output_ready,
   output logic                  frame_error,
   output logic                  busy
);

   // One extra bit beyond the index width, so the counter can reach
   // DATA_WIDTH without wrapping.
   localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_STOP  = 2'd2,
      ST_BREAK = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  ready_q, ready_d;
   logic                  ferr_q,  ferr_d;

   // State, counter, shift register and registered outputs.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Any low sample on an idle line is taken as a start bit.
            if (!rx) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_DATA: begin
            // Write the sampled bit into the position the counter points to.
            // This is an explicit decode, so an index never falls outside the
            // range of the shift register.
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  shift_d[i] = rx;
               end else begin
                  shift_d[i] = shift_q[i];
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_DATA;
            end
         end

         ST_STOP: begin
            if (rx) begin
               data_d  = shift_q;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               // data_out keeps the last good word.
               ferr_d  = 1'b1;
               state_d = ST_BREAK;
            end
         end

         ST_BREAK: begin
            // A held-low line is a break, not a run of start bits.
            if (rx) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign data_out     = data_q;
   assign output_ready = ready_q;
   assign frame_error  = ferr_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Receive-side counterpart of the transmitter control path. It samples a single-bit serial line at one bit per `clk` cycle and recovers frames of one start bit (0), DATA_WIDTH data bits (LSB first) and one stop bit (1). It presents each recovered word on a parallel output with a one-cycle `output_ready` strobe and flags malformed frames. It sits at the far end of the serial link, clocked by the same `clk` as the transmitter.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame. Legal range is 1–16.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `arst`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: serial line. Idle level is 1. Synchronous to `clk` (same-clock link), so it has no synchronizer.
- `data_out`  out  DATA_WIDTH: last correctly received word. Held until the next good frame.
- `output_ready`  out  1: one-cycle pulse when `data_out` is updated.
- `frame_error`  out  1: one-cycle pulse when the stop bit is sampled as 0.
- `busy`  out  1: high while in any state other than IDLE.

## Operation
- Reset (`arst`=0) applies immediately, regardless of clock:
  - state = IDLE, bit counter = 0, shift register = 0.
  - `data_out` = 0, `output_ready` = 0, `frame_error` = 0, `busy` = 0.
- State machine, evaluated on `rx` as sampled at each rising edge:
  - **IDLE**: `rx`=0 → DATA, with counter cleared to 0. `rx`=1 → stay in IDLE.
  - **DATA**: shift `rx` into the register at bit position `counter` (LSB first). Then increment the counter. When counter = DATA_WIDTH-1 at the edge, go to STOP.
  - **STOP**, `rx`=1: load `data_out` from the shift register, pulse `output_ready`, go to IDLE.
  - **STOP**, `rx`=0: pulse `frame_error`, leave `data_out` unchanged, go to BREAK.
  - **BREAK**: wait for `rx`=1, then go to IDLE. A low line here is never treated as a start bit.
- Counter width is ceil(log2(DATA_WIDTH))+1 bits. It never wraps; it is cleared on IDLE→DATA.
- `output_ready` and `frame_error` are registered and mutually exclusive. Each is high for exactly one cycle per frame.
- `busy` is decoded from the state register: 1 in DATA, STOP and BREAK.
- No glitch suppression. A single-cycle 0 on an idle line is a start bit, and a full frame is collected.

## Timing
- Start bit sampled at edge N:
  - Data bits are sampled at edges N+1 … N+DATA_WIDTH.
  - The stop bit is sampled at edge N+DATA_WIDTH+1.
  - `output_ready` or `frame_error` is high during the cycle after edge N+DATA_WIDTH+1 (for DATA_WIDTH=8, the cycle after edge N+9).
- `data_out` changes on the same edge that raises `output_ready`. It is stable for the whole strobe cycle and afterwards.
- Back-to-back frames: the next start bit may be sampled at edge N+DATA_WIDTH+2, the first edge back in IDLE. Continuous streams are therefore received with no lost frames, matching the transmitter's 10-cycle frame for DATA_WIDTH=8.
- `busy` is high from edge N+1 through edge N+DATA_WIDTH+1. It remains high in BREAK until the edge after `rx` returns to 1.
- Reset mid-frame:
  - The partial frame is discarded and all outputs go to their reset values immediately.
  - After release, reception resumes only from a new start bit sampled in IDLE.

## Test plan
- **Reset values**: hold `arst`=0 with `rx` toggling. All outputs stay 0 and `busy`=0. After release with `rx`=1, nothing changes.
- **Single frame 0xA5**: drive `rx` = 0,1,0,1,0,0,1,0,1,1 starting at edge N. Require `data_out`=8'hA5 and `output_ready`=1 for exactly one cycle after edge N+9, with `frame_error`=0.
- **Back-to-back 0x00 then 0xFF**: drive 0,0×8,1 immediately followed by 0,1×8,1. Require two strobes 10 cycles apart, carrying 8'h00 then 8'hFF.
- **Framing error**: drive frame 0x3C with the stop bit at 0, then hold `rx`=0 for 5 cycles, then 1.
  - Require a `frame_error` pulse and no `output_ready`.
  - `data_out` keeps its prior value.
  - No new frame starts while the line is held low.
  - `busy` falls after `rx` returns high.
- **Reset mid-frame**: assert `arst` after 4 data bits, then release and send 0x5A. Require an immediate return to reset values, then a single clean 8'h5A strobe.
- **Parameter**: with DATA_WIDTH=5, send 5'h13. Require the strobe after edge N+6 with `data_out`=5'h13.
